// File: rtl/lsu_bridge.sv
// lsu_bridge: turns one CPU load/store (byte/half/word, any alignment) into
// one or two word-aligned memory accesses, with lane enables, data
// alignment, load extension and a per-access ack timeout.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_ready is 1 only while idle. The memory side
// holds mem_req and all mem_* fields stable until a cycle with mem_ack=1,
// and that cycle completes the access. mem_ack with mem_req=0 has no effect.
// resp_valid is a one-cycle pulse with no back-pressure.
module lsu_bridge #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [1:0]  off;
  logic [2:0]  nbytes;
  logic        crosses;
  logic [3:0]  lane_mask;
  logic [7:0]  be_wide;
  logic [63:0] wd_wide;
  logic [5:0]  sh_hi;
  logic [31:0] rd_lo;
  logic [31:0] rd_hi;
  logic [31:0] word_addr;
  logic        in_acc;
  logic        expired;

  // Alignment helpers derived from the latched request
  always_comb begin
    off       = addr_q[1:0];
    nbytes    = 3'd4;
    lane_mask = 4'b1111;
    case (size_q)
      2'b00:   begin nbytes = 3'd1; lane_mask = 4'b0001; end
      2'b01:   begin nbytes = 3'd2; lane_mask = 4'b0011; end
      default: begin nbytes = 3'd4; lane_mask = 4'b1111; end
    endcase
    crosses   = ({1'b0, off} + nbytes) > 3'd4;
    // Lanes and data laid out over two consecutive words: low half is the
    // first access, high half the second.
    be_wide   = {4'b0000, lane_mask} << off;
    wd_wide   = {32'd0, wdata_q} << {off, 3'b000};
    sh_hi     = 6'd32 - {1'b0, off, 3'b000};
    rd_lo     = mem_rdata >> {off, 3'b000};
    rd_hi     = mem_rdata << sh_hi;
    word_addr = {addr_q[31:2], 2'b00};
    in_acc    = (state_q == ACC0) || (state_q == ACC1);
    expired   = in_acc && !mem_ack && (cnt_q == CNT_LAST);
  end

  // Next-state, request latch, load assembly and wait counter
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'd0;
          err_d   = (req_size == 2'b11);
          state_d = (req_size == 2'b11) ? RESP : ACC0;
        end
      end
      ACC0: begin
        if (mem_ack) begin
          if (!we_q) rdata_d = rd_lo;
          state_d = crosses ? ACC1 : RESP;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ACC1: begin
        if (mem_ack) begin
          if (!we_q) rdata_d = rdata_q | rd_hi;
          state_d = RESP;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any access in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded from state; everything idles at zero outside its phase
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'd0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'b0000;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    case (state_q)
      IDLE: req_ready = 1'b1;
      ACC0: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_be    = be_wide[3:0];
        mem_addr  = word_addr;
        mem_wdata = wd_wide[31:0];
      end
      ACC1: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_be    = be_wide[7:4];
        mem_addr  = word_addr + 32'd4;
        mem_wdata = wd_wide[63:32];
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!we_q && !err_q) begin
          case (size_q)
            2'b00:   resp_rdata = uns_q ? {24'd0, rdata_q[7:0]}
                                        : {{24{rdata_q[7]}}, rdata_q[7:0]};
            2'b01:   resp_rdata = uns_q ? {16'd0, rdata_q[15:0]}
                                        : {{16{rdata_q[15]}}, rdata_q[15:0]};
            default: resp_rdata = rdata_q;
          endcase
        end
      end
      default: ;
    endcase
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_lsu_bridge.sv
// Directed bench for lsu_bridge (TIMEOUT=4). Inputs change and outputs are
// sampled 1ns after each rising edge.
module tb_lsu_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  lsu_bridge #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, exp finish within 200us");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'hFFFF_FFFF; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step(); step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b exp 0", mem_req); end
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp: got v=%b e=%b exp 0 0", resp_valid, resp_err); end
    checks++; if ({mem_we, mem_be, mem_addr, mem_wdata, resp_rdata} !== 101'd0) begin errors++; $display("FAIL reset_buses: got we=%b be=%b a=%h wd=%h rd=%h exp all 0", mem_we, mem_be, mem_addr, mem_wdata, resp_rdata); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", dbg_state); end
    req_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_word_load();
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL wl_ready: got %b exp 1", req_ready); end
    step(); req_valid = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL wl_req: got req=%b we=%b exp 1 0", mem_req, mem_we); end
    checks++; if (mem_addr !== 32'h100 || mem_be !== 4'b1111) begin errors++; $display("FAIL wl_addr_be: got %h %b exp 00000100 1111", mem_addr, mem_be); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wl_busy_ready: got %b exp 0", req_ready); end
    mem_ack = 1'b1; mem_rdata = 32'h8899_AABB;
    step(); mem_ack = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0) begin errors++; $display("FAIL wl_resp: got v=%b e=%b exp 1 0", resp_valid, resp_err); end
    checks++; if (resp_rdata !== 32'h8899_AABB) begin errors++; $display("FAIL wl_rdata: got %h exp 8899aabb", resp_rdata); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL wl_resp_mem_req: got %b exp 0", mem_req); end
    step();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL wl_pulse: got v=%b rdy=%b exp 0 1", resp_valid, req_ready); end
  endtask

  task automatic test_byte_load();
    logic [31:0] exp_rd;
    for (int u = 0; u < 2; u++) begin
      exp_rd = (u == 1) ? 32'h0000_0080 : 32'hFFFF_FF80;
      drive_req(1'b0, 2'b00, u[0], 32'h0000_0103, 32'd0);
      step(); req_valid = 1'b0;
      checks++; if (mem_be !== 4'b1000 || mem_addr !== 32'h100) begin errors++; $display("FAIL bl_be_u%0d: got %b %h exp 1000 00000100", u, mem_be, mem_addr); end
      mem_ack = 1'b1; mem_rdata = 32'h8011_2233;
      step(); mem_ack = 1'b0;
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== exp_rd) begin errors++; $display("FAIL bl_rdata_u%0d: got v=%b %h exp 1 %h", u, resp_valid, resp_rdata, exp_rd); end
      step();
    end
  endtask

  task automatic test_half_store_cross();
    drive_req(1'b1, 2'b01, 1'b0, 32'h0000_0203, 32'h0000_BEEF);
    step(); req_valid = 1'b0;
    checks++; if (mem_addr !== 32'h200 || mem_be !== 4'b1000 || mem_we !== 1'b1) begin errors++; $display("FAIL hs_acc0: got a=%h be=%b we=%b exp 00000200 1000 1", mem_addr, mem_be, mem_we); end
    checks++; if (mem_wdata !== 32'hEF00_0000) begin errors++; $display("FAIL hs_wdata0: got %h exp ef000000", mem_wdata); end
    mem_ack = 1'b1;
    step(); mem_ack = 1'b0;
    checks++; if (resp_valid !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL hs_extra_cycle: got v=%b req=%b exp 0 1", resp_valid, mem_req); end
    checks++; if (mem_addr !== 32'h204 || mem_be !== 4'b0001) begin errors++; $display("FAIL hs_acc1: got a=%h be=%b exp 00000204 0001", mem_addr, mem_be); end
    checks++; if (mem_wdata !== 32'h0000_00BE) begin errors++; $display("FAIL hs_wdata1: got %h exp 000000be", mem_wdata); end
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step(); mem_ack = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin errors++; $display("FAIL hs_resp: got v=%b rd=%h e=%b exp 1 0 0", resp_valid, resp_rdata, resp_err); end
    step();
  endtask

  task automatic test_word_load_cross();
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_00FE, 32'd0);
    step(); req_valid = 1'b0;
    checks++; if (mem_addr !== 32'hFC || mem_be !== 4'b1100) begin errors++; $display("FAIL wc_acc0: got %h %b exp 000000fc 1100", mem_addr, mem_be); end
    mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    step();
    checks++; if (mem_addr !== 32'h100 || mem_be !== 4'b0011) begin errors++; $display("FAIL wc_acc1: got %h %b exp 00000100 0011", mem_addr, mem_be); end
    mem_rdata = 32'h5566_7788;
    step(); mem_ack = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h7788_1122) begin errors++; $display("FAIL wc_rdata: got v=%b %h exp 1 77881122", resp_valid, resp_rdata); end
    step();
  endtask

  task automatic test_wrap_half_load();
    drive_req(1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'd0);
    step(); req_valid = 1'b0;
    checks++; if (mem_addr !== 32'hFFFF_FFFC || mem_be !== 4'b1000) begin errors++; $display("FAIL wr_acc0: got %h %b exp fffffffc 1000", mem_addr, mem_be); end
    mem_ack = 1'b1; mem_rdata = 32'hAB00_0000;
    step();
    checks++; if (mem_addr !== 32'h0 || mem_be !== 4'b0001) begin errors++; $display("FAIL wr_acc1: got %h %b exp 00000000 0001", mem_addr, mem_be); end
    mem_rdata = 32'h0000_00CD;
    step(); mem_ack = 1'b0;
    checks++; if (resp_rdata !== 32'hFFFF_CDAB) begin errors++; $display("FAIL wr_rdata: got %h exp ffffcdab", resp_rdata); end
    step();
  endtask

  task automatic test_timeout();
    int hi;
    int cyc;
    hi = 0; cyc = 0;
    drive_req(1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'h1234_5678);
    step(); req_valid = 1'b0;
    while (resp_valid !== 1'b1 && cyc < 12) begin
      if (mem_req === 1'b1) hi++;
      step();
      cyc++;
    end
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL to_resp: got no resp in %0d cycles exp resp", cyc); end
    checks++; if (hi != 4) begin errors++; $display("FAIL to_req_cycles: got %0d exp 4", hi); end
    checks++; if (resp_err !== 1'b1 || resp_rdata !== 32'd0) begin errors++; $display("FAIL to_err: got e=%b rd=%h exp 1 0", resp_err, resp_rdata); end
    step();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL to_idle: got v=%b rdy=%b exp 0 1", resp_valid, req_ready); end
  endtask

  task automatic test_ack_at_timeout();
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'd0);
    step(); req_valid = 1'b0;
    repeat (3) step();
    checks++; if (mem_req !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL at_wait: got req=%b v=%b exp 1 0", mem_req, resp_valid); end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step(); mem_ack = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL at_resp: got v=%b e=%b rd=%h exp 1 0 cafef00d", resp_valid, resp_err, resp_rdata); end
    step();
  endtask

  task automatic test_reserved();
    drive_req(1'b0, 2'b11, 1'b0, 32'h0000_0500, 32'd0);
    step(); req_valid = 1'b0;
    checks++; if (mem_req !== 1'b0 || resp_valid !== 1'b1 || resp_err !== 1'b1) begin errors++; $display("FAIL rs_resp: got req=%b v=%b e=%b exp 0 1 1", mem_req, resp_valid, resp_err); end
    checks++; if (resp_rdata !== 32'd0) begin errors++; $display("FAIL rs_rdata: got %h exp 0", resp_rdata); end
    step();
    checks++; if (mem_req !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rs_after: got req=%b v=%b exp 0 0", mem_req, resp_valid); end
  endtask

  task automatic test_ignore_ack();
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (resp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL ia_idle%0d: got v=%b req=%b rdy=%b exp 0 0 1", i, resp_valid, mem_req, req_ready); end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_00FE, 32'd0);
    step(); req_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h1122_3344;
    step(); mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL rm_in_acc1: got req=%b a=%h exp 1 00000100", mem_req, mem_addr); end
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rm_async: got req=%b rdy=%b exp 0 1", mem_req, req_ready); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rm_no_resp%0d: got %b exp 0", i, resp_valid); end
    end
    rst = 1'b0;
    step();
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rm_post: got v=%b rdy=%b exp 0 1", resp_valid, req_ready); end
    drive_req(1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'd0);
    step(); req_valid = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
    step(); mem_ack = 1'b0;
    checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL rm_new_req: got v=%b rd=%h exp 1 0badf00d", resp_valid, resp_rdata); end
    step();
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store_cross();
    test_word_load_cross();
    test_wrap_half_load();
    test_timeout();
    test_ack_at_timeout();
    test_reserved();
    test_ignore_ack();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
